// File: rtl/register_serializer_pkg.sv
// Shared state encoding and sizing helper for the parallel-to-serial converter.
package register_serializer_pkg;

   localparam logic STATE_IDLE  = 1'b0;
   localparam logic STATE_SHIFT = 1'b1;

   typedef enum logic {
      ST_IDLE  = STATE_IDLE,
      ST_SHIFT = STATE_SHIFT
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/register_serializer_down_counter.sv
// Loadable down-counter that saturates at zero; tracks the remaining bits of a word.
module down_counter #(
   parameter int Width = 5
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_load,
   input  logic [Width-1:0] i_load_value,
   input  logic             i_dec,
   output logic [Width-1:0] o_count,
   output logic             o_zero
);

   logic [Width-1:0] r_count;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/register_serializer.sv
// Drains one parallel word per handshake onto a single-bit valid/ready stream,
// reloading on the final beat so consecutive words leave without a bubble.
//
// state    | meaning
// ST_IDLE  | no word held, ready to capture
// ST_SHIFT | word held, presenting one bit per beat
module register_serializer
   import register_serializer_pkg::*;
#(
   parameter int Width    = 32,
   parameter bit MsbFirst = 1'b1
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic [Width-1:0] i_in,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_out_bit,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_out_last,
   output logic             o_busy
);

   localparam int CW = cnt_width(Width);
   localparam logic [CW-1:0] LoadValue = CW'(Width - 1);

   state_t           r_state;
   logic [Width-1:0] r_shift;
   logic             r_out_valid;
   logic             r_busy;

   logic [Width-1:0] w_shifted;
   logic [CW-1:0]    w_count;
   logic             w_zero;
   logic             w_beat;
   logic             w_in_ready;
   logic             w_capture;
   logic             w_dec;

   assign w_beat     = r_out_valid & i_out_ready;
   // out_ready feeds in_ready combinationally so a new word lands on the final beat
   assign w_in_ready = i_reset_n &
                       ((r_state == ST_IDLE) |
                        ((r_state == ST_SHIFT) & w_zero & i_out_ready));
   assign w_capture  = w_in_ready & i_in_valid;
   assign w_dec      = w_beat & ~w_zero;

   always_comb begin
      w_shifted = '0;
      if (MsbFirst) begin
         w_shifted = {r_shift[Width-2:0], 1'b0};
      end else begin
         w_shifted = {1'b0, r_shift[Width-1:1]};
      end
   end

   down_counter #(
      .Width(CW)
   ) u_bit_cnt (
      .i_clock      (i_clock),
      .i_reset_n    (i_reset_n),
      .i_load       (w_capture),
      .i_load_value (LoadValue),
      .i_dec        (w_dec),
      .o_count      (w_count),
      .o_zero       (w_zero)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_shift     <= i_in;
                  r_state     <= ST_SHIFT;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (w_beat) begin
                  if (!w_zero) begin
                     r_shift <= w_shifted;
                  end else if (w_capture) begin
                     r_shift <= i_in;
                  end else begin
                     r_shift     <= '0;
                     r_state     <= ST_IDLE;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_out_bit   = r_out_valid & (MsbFirst ? r_shift[Width-1] : r_shift[0]);
   assign o_out_last  = r_out_valid & (w_count == '0);

endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench: stimulus pushes expected {bit,last} pairs, monitors pop on every beat.
module tb_register_serializer;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;

   logic [W-1:0] a_in;
   logic         a_valid, a_ready_o, a_bit, a_ovalid, a_oready, a_last, a_busy;
   logic [W-1:0] b_in;
   logic         b_valid, b_ready_o, b_bit, b_ovalid, b_oready, b_last, b_busy;

   logic [1:0]   qa[$];
   logic [1:0]   qb[$];

   int n_checks = 0;
   int n_err    = 0;

   register_serializer #(.Width(W), .MsbFirst(1'b1)) u_dut_msb (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_in        (a_in),
      .i_in_valid  (a_valid),
      .o_in_ready  (a_ready_o),
      .o_out_bit   (a_bit),
      .o_out_valid (a_ovalid),
      .i_out_ready (a_oready),
      .o_out_last  (a_last),
      .o_busy      (a_busy)
   );

   register_serializer #(.Width(W), .MsbFirst(1'b0)) u_dut_lsb (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_in        (b_in),
      .i_in_valid  (b_valid),
      .o_in_ready  (b_ready_o),
      .o_out_bit   (b_bit),
      .o_out_valid (b_ovalid),
      .i_out_ready (b_oready),
      .o_out_last  (b_last),
      .o_busy      (b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_a(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) qa.push_back({w[i], (i == 0)});
   endtask

   task automatic push_b(input logic [W-1:0] w);
      for (int i = 0; i < W; i++) qb.push_back({w[i], (i == W - 1)});
   endtask

   // Monitor for the MSB-first instance: beat check plus stall-hold check.
   logic a_prev_stall;
   logic a_prev_bit, a_prev_last;
   always @(negedge clk) begin
      if (!rst_n) begin
         a_prev_stall = 1'b0;
      end else begin
         if (a_prev_stall && a_ovalid) begin
            chk("a_hold_bit", a_bit, a_prev_bit);
            chk("a_hold_last", a_last, a_prev_last);
         end
         if (a_ovalid && a_oready) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_beat", 1, 0);
            end else begin
               logic [1:0] e;
               e = qa.pop_front();
               chk("a_bit", a_bit, e[1]);
               chk("a_last", a_last, e[0]);
            end
         end
         a_prev_stall = a_ovalid && !a_oready;
         a_prev_bit   = a_bit;
         a_prev_last  = a_last;
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_ovalid && b_oready) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_beat", 1, 0);
         end else begin
            logic [1:0] e;
            e = qb.pop_front();
            chk("b_bit", b_bit, e[1]);
            chk("b_last", b_last, e[0]);
         end
      end
   end

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", (qa.size() != 0 || qb.size() != 0), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      a_in = '0; a_valid = 1'b0; a_oready = 1'b1;
      b_in = '0; b_valid = 1'b0; b_oready = 1'b1;
      #3;
      chk("rst_in_ready", a_ready_o, 0);
      chk("rst_out_valid", a_ovalid, 0);
      chk("rst_out_bit", a_bit, 0);
      chk("rst_out_last", a_last, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_b_in_ready", b_ready_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", a_ready_o, 1);
      chk("idle_b_in_ready", b_ready_o, 1);

      // Reset mid-word
      @(posedge clk); #1;
      a_in = 8'hA5; a_valid = 1'b1; push_a(8'hA5);
      @(posedge clk); #1;
      a_valid = 1'b0;
      chk("t1_busy_after_capture", a_busy, 1);
      repeat (3) @(posedge clk);
      #1 a_oready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_out_valid", a_ovalid, 0);
      chk("t1_async_busy", a_busy, 0);
      chk("t1_async_in_ready", a_ready_o, 0);
      chk("t1_remaining_bits", qa.size(), 5);
      qa.delete();
      @(posedge clk); #1;
      rst_n = 1'b1; a_oready = 1'b1;
      @(negedge clk);
      chk("t1_release_in_ready", a_ready_o, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("t1_no_bits_out_valid", a_ovalid, 0);

      // Single word, continuous ready
      a_in = 8'hA5; a_valid = 1'b1; push_a(8'hA5);
      @(posedge clk); #1;
      a_valid = 1'b0;
      chk("t2_out_valid", a_ovalid, 1);
      repeat (8) @(posedge clk);
      #1;
      chk("t2_busy_after", a_busy, 0);
      chk("t2_all_beats", qa.size(), 0);

      // Backpressure 1,0,0,1 repeating
      a_in = 8'h81; a_valid = 1'b1; push_a(8'h81);
      @(posedge clk); #1;
      a_valid = 1'b0;
      begin
         int i;
         i = 0;
         while (qa.size() != 0 && i < 40) begin
            a_oready = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clk); #1;
            i++;
         end
         chk("t3_timeout", qa.size(), 0);
      end
      chk("t3_busy_after", a_busy, 0);
      a_oready = 1'b1;

      // Back-to-back F0, 0F
      a_in = 8'hF0; a_valid = 1'b1; push_a(8'hF0); push_a(8'h0F);
      @(posedge clk); #1;
      a_in = 8'h0F;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("t4_in_ready_c%0d", k), a_ready_o, (k == 8 || k == 16));
         chk($sformatf("t4_valid_c%0d", k), a_ovalid, 1);
         @(posedge clk); #1;
         if (k == 8) a_valid = 1'b0;
      end
      chk("t4_busy_after", a_busy, 0);
      chk("t4_all_beats", qa.size(), 0);

      // LSB-first instance
      b_in = 8'h01; b_valid = 1'b1; push_b(8'h01);
      @(posedge clk); #1;
      b_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("t5_busy_after", b_busy, 0);

      // in changes during SHIFT are ignored
      a_in = 8'h3C; a_valid = 1'b1; push_a(8'h3C);
      @(posedge clk); #1;
      a_valid = 1'b0; a_in = 8'hFF;
      drain(20);
      @(posedge clk); #1;
      chk("t6_busy_after", a_busy, 0);

      repeat (3) @(posedge clk);
      chk("final_queues_empty", qa.size() + qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
